dds_sine_gen: RTL and testbench
===============================

DDS_SINE_GEN -- requirements
Module: dds_sine_gen

Interface
REQ-001 SHALL have parameters: ACC_W, default 32, phase accumulator width; OUT_W, default 12, output sample width; LUT_AW, default 8, quarter-wave LUT address width.
REQ-002 SHALL have ports (clock and reset first): clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  one clock; reset is synchronous and active-low (named rst).
REQ-004 en  in  1  clock enable; pipeline and accumulator advance only when high.
REQ-005 cfg_load  in  1  capture phi_inc and phase_ofs this cycle.
REQ-006 phi_inc  in  ACC_W  phase increment, unsigned.
REQ-007 phase_ofs  in  16  phase offset, unsigned, 2^16 = one full cycle.
REQ-008 sin_o  out  OUT_W  signed two's-complement sine sample.
REQ-009 dac_o  out  OUT_W  offset-binary sample (sin_o + 2048), direct feed to DAC driver.
REQ-010 out_valid  out  1  sin_o/dac_o hold a valid new sample this cycle.

Function
REQ-011 SHALL capture phi_inc into phi_inc_r and phase_ofs into phase_ofs_r on any cycle with cfg_load=1, independent of en.
REQ-012 SHALL update acc <= acc + phi_inc_r (mod 2^ACC_W) on each cycle with en=1; acc holds when en=0.
REQ-013 Same-cycle cfg_load=1 and en=1: accumulator SHALL use the old phi_inc_r; the new value applies from the next enabled cycle.
REQ-014 Stage 1 (en=1): SHALL register phase = acc[ACC_W-1:ACC_W-16] + phase_ofs_r, mod 2^16, wrapping without saturation.
REQ-015 Quadrant q = phase[15:14]; address a = phase[13:6]; q=1 or 3 SHALL use ~a (mirror); q=2 or 3 SHALL flag negate.
REQ-016 Stage 2 (en=1): SHALL register LUT[addr] plus delayed negate flag; LUT[k] = round(2047*sin(pi/2*(k+0.5)/256)), k=0..255, unsigned 11-bit, LUT[0]=6, LUT[255]=2047.
REQ-017 Stage 3 (en=1): SHALL register sin_o = negate ? -LUT : +LUT (range -2047..+2047; -2048 never produced) and dac_o = sin_o + 2048 mod 2^12 (range 1..4095).
REQ-018 Latency SHALL be 3 enabled cycles from an accumulator value to its sample on sin_o/dac_o.
REQ-019 A 2-bit saturating fill counter SHALL increment per enabled cycle from 0 to 3; out_valid = en_d & (fill==3), where en_d is en registered.
REQ-020 With en=0, all pipeline registers, sin_o and dac_o SHALL hold; out_valid SHALL be 0 the following cycle.
REQ-021 phi_inc_r=0 SHALL give a constant output determined by acc and phase_ofs_r only.
REQ-022 No combinational path SHALL exist from any input to any output.

Reset
REQ-023 On rising clk with rst=0: acc=0, phi_inc_r=0, phase_ofs_r=0, all pipeline stages 0, fill=0, sin_o=0, dac_o=2048, out_valid=0.
REQ-024 Reset SHALL take priority over en and cfg_load in the same cycle.
REQ-025 Reset mid-stream SHALL discard all in-flight samples; after release, out_valid SHALL stay 0 until 3 further enabled cycles.

Verification
REQ-026 Quarter step: cfg_load with phi_inc=0x40000000, phase_ofs=0, then en=1 held -> after fill, sin_o repeats +6, +2047, -6, -2047; dac_o repeats 2054, 4095, 2042, 1.
REQ-027 Static offset: phi_inc=0, phase_ofs=0x4000, en=1 -> sin_o=2047, dac_o=4095 constant; out_valid=1 from 4th cycle after reset release.
REQ-028 Wrap: phi_inc=0xFFFFFFFF, phase_ofs=0 -> first valid sample from acc=0 is +6; next from acc=0xFFFFFFFF (phase 0xFFFF, q=3, a mirrored to 0) is -6; no X, no saturation.
REQ-029 Stall: en toggled 1,1,1,1,0,0,1 with phi_inc=0x40000000 -> sin_o holds over en=0 cycles, out_valid 0 on the cycles after en=0, sequence resumes with no skipped or duplicated sample.
REQ-030 Config race: cfg_load=1 with new phi_inc on the same cycle as en=1 -> that step uses the old increment; the next enabled step uses the new one.
REQ-031 Reset mid-run: rst=0 for one cycle during streaming -> next cycle sin_o=0, dac_o=2048, out_valid=0, phi_inc_r=0; after re-load, out_valid returns after 3 enabled cycles.

Source files
------------

// File: rtl/dds_sine_gen.sv
// ---------------------------------------------------------------------------
// dds_sine_gen
// Direct digital synthesis sine generator. A phase accumulator drives a
// quarter-wave sine ROM through a 3-stage enabled pipeline and produces both
// a signed two's-complement sample and an offset-binary DAC code.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   en         clock enable for accumulator, pipeline and fill counter
//   cfg_load   capture phi_inc / phase_ofs this cycle (independent of en)
//   phi_inc    phase increment per enabled cycle, unsigned, ACC_W bits
//   phase_ofs  phase offset, unsigned, 2^16 = one full cycle
//   sin_o      signed sine sample, range -(2^(OUT_W-1)-1)..+(2^(OUT_W-1)-1)
//   dac_o      offset-binary sample, sin_o + 2^(OUT_W-1)
//   out_valid  sin_o/dac_o carry a new valid sample this cycle
// ---------------------------------------------------------------------------
module dds_sine_gen #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 12,
  parameter int unsigned LUT_AW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [ACC_W-1:0]        phi_inc,
  input  logic [15:0]             phase_ofs,
  output logic signed [OUT_W-1:0] sin_o,
  output logic [OUT_W-1:0]        dac_o,
  output logic                    out_valid
);

  localparam int unsigned PH_W   = 16;
  localparam int unsigned LUT_N  = 1 << LUT_AW;
  localparam int unsigned LUT_DW = OUT_W - 1;
  localparam int unsigned FRAC   = 28;

  // pi in Q28 fixed point
  localparam longint PI_Q = 64'sd843314857;

  localparam logic [OUT_W-1:0] DAC_OFS = OUT_W'(1) << (OUT_W - 1);

  // Builds the quarter-wave table at elaboration time:
  // LUT[k] = round(AMP * sin(pi/2 * (k + 0.5) / LUT_N)), AMP = 2^(OUT_W-1)-1.
  // Sine is evaluated by a Q28 Taylor series; nine terms keep the error far
  // below one output LSB over 0..pi/2, so rounding matches the real value.
  function automatic logic [LUT_N*LUT_DW-1:0] build_lut();
    logic [LUT_N*LUT_DW-1:0] tbl;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    longint val;
    tbl = '0;
    amp = (longint'(1) <<< LUT_DW) - longint'(1);
    for (int k = 0; k < int'(LUT_N); k++) begin
      x    = (PI_Q * longint'(2 * k + 1)) / longint'(4 * LUT_N);
      x2   = (x * x) >>> FRAC;
      term = x;
      sum  = x;
      for (int n = 1; n <= 9; n++) begin
        term = -((term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      val = (amp * sum + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
      tbl[k*LUT_DW +: LUT_DW] = LUT_DW'(val);
    end
    return tbl;
  endfunction

  localparam logic [LUT_N*LUT_DW-1:0] LUT_ROM = build_lut();

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  phi_inc_r;
  logic [PH_W-1:0]   phase_ofs_r;
  logic [PH_W-1:0]   phase_r;
  logic [LUT_DW-1:0] lut_r;
  logic              neg_r;
  logic [1:0]        fill;

  logic [PH_W-1:0]         phase_c;
  logic [LUT_AW-1:0]       addr_c;
  logic [LUT_DW-1:0]       lut_c;
  logic signed [OUT_W-1:0] sin_c;

  // Phase mapping, quadrant folding, ROM read and sign application
  always_comb begin
    phase_c = acc[ACC_W-1 -: PH_W] + phase_ofs_r;
    // quadrants 1 and 3 read the table mirrored
    addr_c  = phase_r[PH_W-3 -: LUT_AW];
    if (phase_r[PH_W-2]) begin
      addr_c = ~addr_c;
    end
    lut_c   = LUT_ROM[int'(addr_c)*LUT_DW +: LUT_DW];
    // magnitude never reaches 2^(OUT_W-1), so negation cannot overflow
    sin_c   = neg_r ? -$signed({1'b0, lut_r}) : $signed({1'b0, lut_r});
  end

  // Configuration capture, accumulator, pipeline and valid tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc         <= '0;
      phi_inc_r   <= '0;
      phase_ofs_r <= '0;
      phase_r     <= '0;
      lut_r       <= '0;
      neg_r       <= 1'b0;
      fill        <= 2'd0;
      sin_o       <= '0;
      dac_o       <= DAC_OFS;
      out_valid   <= 1'b0;
    end else begin
      if (cfg_load) begin
        phi_inc_r   <= phi_inc;
        phase_ofs_r <= phase_ofs;
      end
      if (en) begin
        // old phi_inc_r is used when cfg_load coincides with en
        acc     <= acc + phi_inc_r;
        phase_r <= phase_c;
        lut_r   <= lut_c;
        neg_r   <= phase_r[PH_W-1];
        sin_o   <= sin_c;
        dac_o   <= $unsigned(sin_c) + DAC_OFS;
        if (fill != 2'd3) begin
          fill <= fill + 2'd1;
        end
      end
      // equals en_d & (fill == 3) with fill taken after this edge's update
      out_valid <= en && (fill >= 2'd2);
    end
  end

endmodule

// File: tb/tb_dds_sine_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_sine_gen
// Directed self-checking bench for dds_sine_gen with hand-computed samples.
// ---------------------------------------------------------------------------
module tb_dds_sine_gen;

  logic               clk;
  logic               rst;
  logic               en;
  logic               cfg_load;
  logic [31:0]        phi_inc;
  logic [15:0]        phase_ofs;
  logic signed [11:0] sin_o;
  logic [11:0]        dac_o;
  logic               out_valid;

  int checks;
  int errors;

  dds_sine_gen #(
    .ACC_W (32),
    .OUT_W (12),
    .LUT_AW(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_load (cfg_load),
    .phi_inc  (phi_inc),
    .phase_ofs(phase_ofs),
    .sin_o    (sin_o),
    .dac_o    (dac_o),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling / driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int s, input int v);
    check({tag, ".sin"}, int'(sin_o), s);
    check({tag, ".dac"}, int'(dac_o), s + 2048);
    check({tag, ".valid"}, int'(out_valid), v);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'b0;
    cfg_load = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic load(input logic [31:0] inc, input logic [15:0] ofs);
    cfg_load = 1'b1;
    phi_inc = inc;
    phase_ofs = ofs;
    en = 1'b0;
    step();
    cfg_load = 1'b0;
  endtask

  // two enabled edges during which out_valid must stay low
  task automatic fill(input string tag);
    en = 1'b1;
    step();
    check({tag, ".fill1"}, int'(out_valid), 0);
    step();
    check({tag, ".fill2"}, int'(out_valid), 0);
  endtask

  task automatic stream(input string tag, input int s);
    en = 1'b1;
    step();
    expect_out(tag, s, 1);
  endtask

  int qexp[4] = '{6, 2047, -6, -2047};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en = 1'b0;
    cfg_load = 1'b0;
    phi_inc = '0;
    phase_ofs = '0;

    // reset beats simultaneous en and cfg_load
    rst = 1'b0;
    en = 1'b1;
    cfg_load = 1'b1;
    phi_inc = 32'h1234_5678;
    phase_ofs = 16'h4000;
    step();
    expect_out("reset", 0, 0);
    rst = 1'b1;
    cfg_load = 1'b0;
    fill("prio");
    stream("prio0", 6);
    stream("prio1", 6);

    // static offset: quarter-cycle phase gives constant full scale
    do_reset();
    load(32'h0, 16'h4000);
    fill("static");
    for (int i = 0; i < 3; i++) stream($sformatf("static%0d", i), 2047);

    // quarter-cycle step through all four quadrants
    do_reset();
    load(32'h4000_0000, 16'h0);
    fill("quarter");
    for (int i = 0; i < 8; i++) stream($sformatf("quarter%0d", i), qexp[i % 4]);

    // reset mid-stream clears outputs and the increment
    rst = 1'b0;
    en = 1'b1;
    step();
    expect_out("midrst", 0, 0);
    rst = 1'b1;
    fill("midrst");
    stream("midrst0", 6);
    stream("midrst1", 6);

    // stall: outputs hold, valid drops, sequence resumes in order
    do_reset();
    load(32'h4000_0000, 16'h0);
    fill("stall");
    stream("stall0", 6);
    stream("stall1", 2047);
    en = 1'b0;
    step();
    expect_out("stall_hold0", 2047, 0);
    step();
    expect_out("stall_hold1", 2047, 0);
    stream("stall2", -6);
    stream("stall3", -2047);
    stream("stall4", 6);

    // config race: first enabled step uses the old increment
    do_reset();
    load(32'h4000_0000, 16'h0);
    en = 1'b1;
    cfg_load = 1'b1;
    phi_inc = 32'h8000_0000;
    step();
    cfg_load = 1'b0;
    check("race.fill1", int'(out_valid), 0);
    step();
    check("race.fill2", int'(out_valid), 0);
    stream("race0", 6);
    stream("race1", 2047);
    stream("race2", -2047);
    stream("race3", 2047);

    // accumulator wrap through 0xFFFFFFFF
    do_reset();
    load(32'hFFFF_FFFF, 16'h0);
    fill("wrap");
    stream("wrap0", 6);
    stream("wrap1", -6);
    stream("wrap2", -6);

    // phase offset addition wraps modulo 2^16
    do_reset();
    load(32'h8000_0000, 16'hC000);
    fill("ofswrap");
    stream("ofswrap0", -2047);
    stream("ofswrap1", 2047);
    stream("ofswrap2", -2047);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
